mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_perf_counter.sv | 23 ++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline package: memory arbiter state type and arbitration helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    localparam logic [3:0] FETCH_BYTEENABLE = 4'hF;
    localparam logic [31:0] PERF_COUNT_MAX  = 32'hFFFF_FFFF;

    // On a tie the port that did not win last time is chosen.
    function automatic arb_state_t arb_pick(input logic fetch_req, input logic data_req,
                                            input arb_state_t last_grant);
        arb_state_t pick;
        pick = ARB_IDLE;
        if (fetch_req && data_req) begin
            pick = (last_grant == ARB_DATA) ? ARB_FETCH : ARB_DATA;
        end else if (data_req) begin
            pick = ARB_DATA;
        end else if (fetch_req) begin
            pick = ARB_FETCH;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_perf_counter.sv
// Saturating 32-bit event counter used for arbiter performance statistics.
module mem_arb_perf_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'd0;
        end else if (enable && (count_q != PERF_COUNT_MAX)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one Avalon-style memory port.
// Optional perf counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,

    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,

    output logic        fetch_mem_sel
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_fetch_wait,
    output logic [31:0] perf_data_busy
`endif
);

    arb_state_t state_q, state_d;
    arb_state_t last_grant_q, last_grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_FETCH;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_address    = d_addr;
        avm_byteenable = d_byteenable;
        avm_writedata  = d_wdata;
        if_ready       = 1'b0;
        d_ready        = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                state_d = arb_pick(if_req, d_read | d_write, last_grant_q);
                if (state_d != ARB_IDLE) begin
                    last_grant_d = state_d;
                end
            end
            ARB_FETCH: begin
                avm_read       = 1'b1;
                avm_address    = if_addr;
                avm_byteenable = FETCH_BYTEENABLE;
                if_ready       = ~avm_waitrequest;
                if (!avm_waitrequest) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_DATA: begin
                // A write wins when the requester raises both strobes.
                avm_write = d_write;
                avm_read  = d_read & ~d_write;
                d_ready   = ~avm_waitrequest;
                if (!avm_waitrequest) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign if_rdata      = avm_readdata;
    assign d_rdata       = avm_readdata;
    assign fetch_mem_sel = (state_q != ARB_DATA);

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf_counter u_fetch_wait_ctr (
        .clk    (clk),
        .reset  (reset),
        .enable (if_req & ~if_ready),
        .count  (perf_fetch_wait)
    );

    mem_arb_perf_counter u_data_busy_ctr (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == ARB_DATA),
        .count  (perf_data_busy)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected accesses queued by the driver,
// checked by an independent monitor on the opposite clock edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [3:0]  d_byteenable;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        fetch_mem_sel;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_fetch_wait;
    logic [31:0] perf_data_busy;
`endif

    mem_port_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_rdata        (if_rdata),
        .if_ready        (if_ready),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_addr          (d_addr),
        .d_byteenable    (d_byteenable),
        .d_wdata         (d_wdata),
        .d_rdata         (d_rdata),
        .d_ready         (d_ready),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .fetch_mem_sel   (fetch_mem_sel)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_fetch_wait (perf_fetch_wait),
        .perf_data_busy  (perf_data_busy)
`endif
    );

    typedef struct {
        bit          is_fetch;
        logic [31:0] addr;
        bit          rd;
        bit          wr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        mon_t;
    int          checks;
    int          errors;
    bit          fetch_done;
    bit          data_done;
    bit          prev_ready;
    bit          last_grant_data_m;
    int          wait_mode;     // 0: no wait, 1: random wait, 2: driven by main
    logic [31:0] rd_drv;
    int          cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory side: fresh read data every cycle, waitrequest per mode.
    initial begin
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'd0;
        rd_drv          = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            rd_drv       = $urandom;
            avm_readdata = rd_drv;
            if (wait_mode == 1) avm_waitrequest = ($urandom_range(0, 2) == 0);
            else if (wait_mode == 0) avm_waitrequest = 1'b0;
        end
    end

    // Monitor: every bus access must match the head of the expected queue.
    initial begin
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ready = 1'b0;
                continue;
            end
            if (prev_ready) begin
                check("idle_after_ready_read", avm_read, 0);
                check("idle_after_ready_write", avm_write, 0);
                check("idle_after_ready_sel", fetch_mem_sel, 1);
            end
            prev_ready = 1'b0;
            if (avm_read || avm_write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access actual=addr %h required=no access",
                             avm_address);
                end else begin
                    mon_t = exp_q[0];
                    check("grant_port", fetch_mem_sel, mon_t.is_fetch);
                    check("avm_address", avm_address, mon_t.addr);
                    check("avm_read", avm_read, mon_t.rd);
                    check("avm_write", avm_write, mon_t.wr);
                    check("avm_byteenable", avm_byteenable, mon_t.be);
                    if (mon_t.wr) check("avm_writedata", avm_writedata, mon_t.wdata);
                    check("ready_vs_wait", {if_ready, d_ready},
                          avm_waitrequest ? 2'b00 : (mon_t.is_fetch ? 2'b10 : 2'b01));
                    if (!avm_waitrequest) begin
                        if (mon_t.is_fetch) begin
                            check("if_rdata", if_rdata, rd_drv);
                            fetch_done = 1'b1;
                        end else begin
                            check("d_rdata", d_rdata, rd_drv);
                            data_done = 1'b1;
                        end
                        void'(exp_q.pop_front());
                        prev_ready = 1'b1;
                    end
                end
            end else if (if_ready || d_ready) begin
                checks++;
                errors++;
                $display("FAIL ready_without_access actual=%b%b required=00", if_ready, d_ready);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset        = 1'b1;
        if_req       = 1'b0;
        d_read       = 1'b0;
        d_write      = 1'b0;
        @(posedge clk);
        #1;
        reset             = 1'b0;
        exp_q.delete();
        last_grant_data_m = 1'b0;
    endtask

    // Issue a fetch and/or data request, queue expected order, hold until served.
    task automatic run_txn(input bit f, input bit d, input bit drd, input bit dwr,
                           input logic [31:0] fa, input logic [31:0] da,
                           input logic [3:0] be, input logic [31:0] wd, output int cycles);
        txn_t ft;
        txn_t dt;
        @(posedge clk);
        #1;
        ft.is_fetch = 1'b1; ft.addr = fa; ft.rd = 1'b1; ft.wr = 1'b0;
        ft.be = 4'hF; ft.wdata = 32'd0;
        dt.is_fetch = 1'b0; dt.addr = da; dt.rd = drd & ~dwr; dt.wr = dwr;
        dt.be = be; dt.wdata = wd;
        if (f && d) begin
            if (last_grant_data_m) begin
                exp_q.push_back(ft);
                exp_q.push_back(dt);
            end else begin
                exp_q.push_back(dt);
                exp_q.push_back(ft);
            end
        end else if (f) begin
            exp_q.push_back(ft);
            last_grant_data_m = 1'b0;
        end else if (d) begin
            exp_q.push_back(dt);
            last_grant_data_m = 1'b1;
        end
        fetch_done   = !f;
        data_done    = !d;
        if_req       = f;
        if_addr      = fa;
        d_read       = drd & d;
        d_write      = dwr & d;
        d_addr       = da;
        d_byteenable = be;
        d_wdata      = wd;
        cycles = 0;
        while (!(fetch_done && data_done) && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
            if (fetch_done) if_req = 1'b0;
            if (data_done) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
        end
        if (cycles >= 300) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout actual=%0d cycles required=completion", cycles);
            if_req  = 1'b0;
            d_read  = 1'b0;
            d_write = 1'b0;
        end
    endtask

    initial begin
        checks = 0; errors = 0; wait_mode = 0;
        fetch_done = 1'b1; data_done = 1'b1; last_grant_data_m = 1'b0;
        reset = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        d_read = 1'b0; d_write = 1'b0; d_addr = 32'd0; d_byteenable = 4'd0; d_wdata = 32'd0;
        do_reset();

        @(negedge clk);
        check("reset_avm_read", avm_read, 0);
        check("reset_avm_write", avm_write, 0);
        check("reset_if_ready", if_ready, 0);
        check("reset_d_ready", d_ready, 0);
        check("reset_fetch_mem_sel", fetch_mem_sel, 1);

        run_txn(1, 0, 0, 0, 32'hBFC0_0000, 32'd0, 4'h0, 32'd0, cyc);
        check("fetch_latency", cyc, 2);

        // Tie after reset: data first, then fetch, then data again.
        do_reset();
        run_txn(1, 1, 1, 0, 32'hBFC0_0004, 32'h0000_1000, 4'hF, 32'd0, cyc);
        check("tie_latency", cyc, 4);
        run_txn(1, 1, 1, 0, 32'hBFC0_0008, 32'h0000_1004, 4'hF, 32'd0, cyc);
        check("tie_latency_repeat", cyc, 4);

        run_txn(0, 1, 1, 1, 32'd0, 32'h0000_2040, 4'hC, 32'h1234_5678, cyc);

        // Write held off by three waitrequest cycles.
        do_reset();
        wait_mode = 2;
        @(posedge clk);
        #1;
        avm_waitrequest = 1'b1;
        begin
            txn_t wt;
            wt.is_fetch = 1'b0; wt.addr = 32'h0000_2000; wt.rd = 1'b0; wt.wr = 1'b1;
            wt.be = 4'b0011; wt.wdata = 32'hDEAD_BEEF;
            exp_q.push_back(wt);
        end
        data_done = 1'b0; d_write = 1'b1; d_wdata = 32'hDEAD_BEEF;
        d_addr = 32'h0000_2000; d_byteenable = 4'b0011;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) avm_waitrequest = 1'b0;
            @(negedge clk);
            check("wait_write_d_ready", d_ready, (i == 4));
            check("wait_write_avm_write", avm_write, 1);
        end
        @(posedge clk);
        #1;
        d_write = 1'b0;
        wait_mode = 0;
        last_grant_data_m = 1'b1;
        @(negedge clk);
        check("wait_write_idle", avm_write, 0);

        // Reset while a data read is stalled.
        do_reset();
        wait_mode = 2;
        @(posedge clk);
        #1;
        avm_waitrequest = 1'b1;
        begin
            txn_t rt;
            rt.is_fetch = 1'b0; rt.addr = 32'h0000_3000; rt.rd = 1'b1; rt.wr = 1'b0;
            rt.be = 4'hF; rt.wdata = 32'd0;
            exp_q.push_back(rt);
        end
        data_done = 1'b0; d_read = 1'b1; d_addr = 32'h0000_3000; d_byteenable = 4'hF;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_owned_by_data", fetch_mem_sel, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("stall_no_ready_pre_reset", d_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0; d_read = 1'b0; exp_q.delete(); last_grant_data_m = 1'b0;
        avm_waitrequest = 1'b0; wait_mode = 0;
        @(negedge clk);
        check("rst_abort_avm_read", avm_read, 0);
        check("rst_abort_avm_write", avm_write, 0);
        check("rst_abort_d_ready", d_ready, 0);
        check("rst_abort_fetch_mem_sel", fetch_mem_sel, 1);

        // Randomized mix with random waitrequest.
        wait_mode = 1;
        for (int n = 0; n < 150; n++) begin
            bit f;
            bit d;
            int k;
            f = $urandom_range(0, 1);
            d = $urandom_range(0, 1);
            if (!f && !d) f = 1'b1;
            k = $urandom_range(0, 2);
            run_txn(f, d, (k != 1), (k != 0), $urandom, $urandom,
                    4'($urandom_range(1, 15)), $urandom, cyc);
        end
        wait_mode = 0;

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
